// File: rtl/ad2dma_deadlock_reporter.sv
// ----------------------------------------------------------------------------
// ad2dma_deadlock_reporter
//
// Purpose:
//   Watches the block flag from the upstream AXIS deadlock monitor. When block
//   stays high for THRESHOLD consecutive armed cycles, the module declares a
//   deadlock. It bumps a saturating event counter and offers one 32-bit report
//   word to a downstream consumer over a valid/ready handshake. It then keeps
//   deadlock high until block drops.
//
// Parameters:
//   THRESHOLD     consecutive blocked cycles that declare a deadlock (2..65535)
//
// Ports:
//   clock            in   rising-edge clock for all state
//   reset            in   synchronous, active-high reset
//   enable           in   arms detection when high
//   clear            in   synchronous soft clear of all state and counters
//   block            in   monitor block flag
//   axis_block_info  in   [3:0] per-channel AXIS block code (two bits/channel)
//   deadlock         out  deadlock-declared flag
//   event_count      out  [11:0] deadlocks declared since reset/clear, saturating
//   rpt_valid        out  report word valid
//   rpt_ready        in   report consumer ready
//   rpt_data         out  [31:0] {event_count[11:0], sticky info[3:0], start timestamp[15:0]}
//   fsm_state        out  [1:0] current FSM state (debug observation)
//
// Report handshake:
//   A report word transfers on a rising edge where rpt_valid and rpt_ready are
//   both high. Once rpt_valid rises, it stays high and rpt_data stays constant
//   until that transfer. Only reset or clear can withdraw a report early.
//   rpt_ready may change freely and has no combinational path to any output.
// ----------------------------------------------------------------------------
module ad2dma_deadlock_reporter #(
  parameter int unsigned THRESHOLD = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic        block,
  input  logic [3:0]  axis_block_info,
  output logic        deadlock,
  output logic [11:0] event_count,
  output logic        rpt_valid,
  input  logic        rpt_ready,
  output logic [31:0] rpt_data,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // The run counter holds the number of blocked samples already taken in
  // COUNT. The sample that arrives while it reads THRESHOLD-1 is therefore
  // the THRESHOLD-th blocked sample.
  localparam logic [15:0] HIT_COUNT = 16'(THRESHOLD - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] run_count;
  logic [15:0] run_next;
  logic [3:0]  sticky;
  logic [3:0]  sticky_next;
  logic [15:0] start_ts;
  logic [15:0] start_next;
  logic [15:0] timestamp;
  logic [11:0] count_q;
  logic [11:0] count_next;
  logic [11:0] count_inc;
  logic [31:0] data_q;
  logic [31:0] data_next;
  logic [3:0]  sticky_now;

  // --------------------------------------------------------------------------
  // Next-state and datapath updates
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    run_next    = run_count;
    sticky_next = sticky;
    start_next  = start_ts;
    count_next  = count_q;
    data_next   = data_q;

    // The report must include the info seen on the hit cycle itself.
    sticky_now  = sticky | axis_block_info;
    count_inc   = (count_q == 12'hFFF) ? 12'hFFF : count_q + 12'd1;

    case (state)
      IDLE: begin
        if (enable && block) begin
          state_next  = COUNT;
          run_next    = 16'd1;
          sticky_next = axis_block_info;
          // The report timestamp marks where the blocked run began.
          start_next  = timestamp;
        end
      end

      COUNT: begin
        if (!enable || !block) begin
          state_next  = IDLE;
          run_next    = 16'd0;
          sticky_next = 4'd0;
        end else if (run_count == HIT_COUNT) begin
          state_next  = REPORT;
          count_next  = count_inc;
          data_next   = {count_inc, sticky_now, start_ts};
          run_next    = 16'd0;
          sticky_next = 4'd0;
        end else begin
          run_next    = run_count + 16'd1;
          sticky_next = sticky_now;
        end
      end

      REPORT: begin
        // Block and enable are ignored here. Only the handshake moves on.
        if (rpt_ready) begin
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (!block) begin
          state_next = IDLE;
          run_next   = 16'd0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers. Clear behaves exactly like reset and overrides any
  // threshold hit or handshake on the same edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state     <= IDLE;
      run_count <= 16'd0;
      sticky    <= 4'd0;
      start_ts  <= 16'd0;
      timestamp <= 16'd0;
      count_q   <= 12'd0;
      data_q    <= 32'd0;
    end else begin
      state     <= state_next;
      run_count <= run_next;
      sticky    <= sticky_next;
      start_ts  <= start_next;
      timestamp <= timestamp + 16'd1;
      count_q   <= count_next;
      data_q    <= data_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs are decoded from registered state, so rpt_valid changes only
  // when the state changes.
  // --------------------------------------------------------------------------
  assign deadlock    = (state == REPORT) || (state == HOLD);
  assign rpt_valid   = (state == REPORT);
  assign event_count = count_q;
  assign rpt_data    = data_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_ad2dma_deadlock_reporter.sv
// ----------------------------------------------------------------------------
// tb_ad2dma_deadlock_reporter
//
// Bench for ad2dma_deadlock_reporter. It uses two instances:
//   dut_a  THRESHOLD=1024  directed scenarios plus randomized blocked runs
//   dut_b  THRESHOLD=2     counter saturation, reset during a report, and
//                          fully random traffic
//
// A behavioural model tracks blocked-run length, pending/held report flags,
// and the event total. Every cycle, the outputs of both instances are
// compared against that model. Hand-computed literal checks pin the model.
// ----------------------------------------------------------------------------
module tb_ad2dma_deadlock_reporter;

  localparam int unsigned THR_A = 1024;
  localparam int unsigned THR_B = 2;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, en_a, clr_a, blk_a, rdy_a;
  logic [3:0]  info_a;
  logic        dl_a, v_a;
  logic [11:0] ec_a;
  logic [31:0] data_a;
  logic [1:0]  st_a;

  logic        rst_b, en_b, clr_b, blk_b, rdy_b;
  logic [3:0]  info_b;
  logic        dl_b, v_b;
  logic [11:0] ec_b;
  logic [31:0] data_b;
  logic [1:0]  st_b;

  ad2dma_deadlock_reporter #(.THRESHOLD(THR_A)) dut_a (
    .clock(clock), .reset(rst_a), .enable(en_a), .clear(clr_a),
    .block(blk_a), .axis_block_info(info_a), .deadlock(dl_a),
    .event_count(ec_a), .rpt_valid(v_a), .rpt_ready(rdy_a),
    .rpt_data(data_a), .fsm_state(st_a)
  );

  ad2dma_deadlock_reporter #(.THRESHOLD(THR_B)) dut_b (
    .clock(clock), .reset(rst_b), .enable(en_b), .clear(clr_b),
    .block(blk_b), .axis_block_info(info_b), .deadlock(dl_b),
    .event_count(ec_b), .rpt_valid(v_b), .rpt_ready(rdy_b),
    .rpt_data(data_b), .fsm_state(st_b)
  );

  logic [47:0] vec_a;
  logic [47:0] vec_b;
  assign vec_a = {dl_a, v_a, ec_a, data_a, st_a};
  assign vec_b = {dl_b, v_b, ec_b, data_b, st_b};

  // ---------------- behavioural model ----------------
  typedef struct {
    int          run;       // consecutive armed blocked samples so far
    int          events;    // unsaturated deadlock total
    bit          pending;   // report offered, not yet taken
    bit          held;      // report taken, waiting for block to drop
    logic [3:0]  sticky;
    logic [15:0] start_ts;
    logic [15:0] ts;
    logic [31:0] word;
  } mdl_t;

  mdl_t m_a;
  mdl_t m_b;

  function automatic logic [11:0] sat12(int e);
    return (e > 4095) ? 12'hFFF : 12'(e);
  endfunction

  function automatic mdl_t model_step(mdl_t m, logic rst, logic clr, logic en,
                                      logic blk, logic [3:0] info, logic rdy,
                                      int thr);
    mdl_t n;
    n = m;
    if (rst || clr) begin
      n.run = 0; n.events = 0; n.pending = 0; n.held = 0;
      n.sticky = 4'd0; n.start_ts = 16'd0; n.ts = 16'd0; n.word = 32'd0;
    end else begin
      n.ts = m.ts + 16'd1;
      if (m.pending) begin
        if (rdy) begin
          n.pending = 0;
          n.held    = 1;
        end
      end else if (m.held) begin
        if (!blk) n.held = 0;
      end else if (en && blk) begin
        if (m.run == 0) begin
          n.start_ts = m.ts;
          n.sticky   = info;
        end else begin
          n.sticky = m.sticky | info;
        end
        n.run = m.run + 1;
        if (n.run == thr) begin
          n.events  = m.events + 1;
          n.word    = {sat12(n.events), n.sticky, n.start_ts};
          n.pending = 1;
          n.run     = 0;
          n.sticky  = 4'd0;
        end
      end else begin
        n.run    = 0;
        n.sticky = 4'd0;
      end
    end
    return n;
  endfunction

  function automatic logic [47:0] exp_vec(mdl_t m);
    logic [1:0] st;
    if (m.pending)      st = S_REPORT;
    else if (m.held)    st = S_HOLD;
    else if (m.run > 0) st = S_COUNT;
    else                st = S_IDLE;
    return {(m.pending || m.held), m.pending, sat12(m.events), m.word, st};
  endfunction

  always @(posedge clock) begin
    m_a <= model_step(m_a, rst_a, clr_a, en_a, blk_a, info_a, rdy_a, int'(THR_A));
    m_b <= model_step(m_b, rst_b, clr_b, en_b, blk_b, info_b, rdy_b, int'(THR_B));
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (checking) begin
      chk("cycle_a", vec_a, exp_vec(m_a));
      chk("cycle_b", vec_b, exp_vec(m_b));
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs are applied just after a falling edge. Each task returns at the
  // next falling edge, where the registered response is visible.
  task automatic step_a(input logic en, input logic blk, input logic [3:0] info,
                        input logic rdy, input logic clr);
    en_a = en; blk_a = blk; info_a = info; rdy_a = rdy; clr_a = clr;
    @(negedge clock);
  endtask

  task automatic step_b(input logic en, input logic blk, input logic [3:0] info,
                        input logic rdy, input logic clr);
    en_b = en; blk_b = blk; info_b = info; rdy_b = rdy; clr_b = clr;
    @(negedge clock);
  endtask

  function automatic logic [3:0] rnd_info();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rnd_pct(int pct);
    return ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0;
  endfunction

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    finish_sim();
  end

  // ---------------- stimulus ----------------
  initial begin
    logic seen;
    int   guard;
    int   len;
    int   drop_at;

    rst_a = 1'b1; en_a = 1'b0; clr_a = 1'b0; blk_a = 1'b0; rdy_a = 1'b0; info_a = 4'd0;
    rst_b = 1'b1; en_b = 1'b0; clr_b = 1'b0; blk_b = 1'b0; rdy_b = 1'b0; info_b = 4'd0;
    repeat (3) @(negedge clock);
    checking = 1'b1;
    chk("reset_state_a", vec_a, 48'h0);
    chk("reset_state_b", vec_b, 48'h0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // One sample short of the threshold: nothing must be declared.
    seen = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      step_a(1'b1, 1'b1, rnd_info(), 1'b0, 1'b0);
      seen = seen | dl_a | v_a;
    end
    step_a(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    seen = seen | dl_a | v_a;
    chk("short_run_quiet", {35'd0, seen, ec_a}, 48'h0);

    // Clear, then start the blocked run at timestamp 0x0010.
    step_a(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    guard = 0;
    while (m_a.ts != 16'h0010 && guard < 100) begin
      step_a(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      guard++;
    end
    if (guard >= 100) chk("ts_align_timeout", 48'd1, 48'd0);
    step_a(1'b1, 1'b1, 4'b1100, 1'b0, 1'b0);
    for (int i = 0; i < 1023; i++) step_a(1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
    chk("first_report", {14'd0, dl_a, v_a, data_a}, {14'd0, 1'b1, 1'b1, 32'h001E0010});

    // Stall the consumer for 10 cycles, then take the word.
    for (int i = 0; i <= 10; i++) begin
      chk("report_stable", {15'd0, v_a, data_a}, {15'd0, 1'b1, 32'h001E0010});
      step_a(1'b1, 1'b1, rnd_info(), (i == 10), 1'b0);
    end
    chk("handshake_to_hold", {44'd0, v_a, dl_a, st_a}, {44'd0, 1'b0, 1'b1, S_HOLD});

    // Release from HOLD, then a second full run.
    step_a(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("hold_release", {45'd0, dl_a, st_a}, {45'd0, 1'b0, S_IDLE});
    for (int i = 0; i < 1024; i++) step_a(1'b1, 1'b1, rnd_info(), 1'b0, 1'b0);
    chk("second_report", {34'd0, v_a, dl_a, data_a[31:20]}, {34'd0, 1'b1, 1'b1, 12'd2});
    step_a(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    step_a(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    // Enable dropped at run count 500 restarts the run.
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step_a(1'b1, 1'b1, rnd_info(), 1'b0, 1'b0);
      seen = seen | dl_a | v_a;
    end
    step_a(1'b0, 1'b1, rnd_info(), 1'b0, 1'b0);
    seen = seen | dl_a | v_a;
    for (int i = 0; i < 600; i++) begin
      step_a(1'b1, 1'b1, rnd_info(), 1'b0, 1'b0);
      seen = seen | dl_a | v_a;
    end
    chk("enable_drop_no_report", {34'd0, seen, v_a, ec_a}, {36'd0, 12'd2});
    step_a(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    // Clear in REPORT with a simultaneous handshake.
    for (int i = 0; i < 1024; i++) step_a(1'b1, 1'b1, rnd_info(), 1'b0, 1'b0);
    chk("third_report_up", {47'd0, v_a}, 48'd1);
    step_a(1'b1, 1'b1, rnd_info(), 1'b1, 1'b1);
    chk("clear_in_report", vec_a, 48'h0);

    // Clear on the same edge as a threshold hit.
    for (int i = 0; i < 1023; i++) step_a(1'b1, 1'b1, rnd_info(), 1'b0, 1'b0);
    step_a(1'b1, 1'b1, rnd_info(), 1'b0, 1'b1);
    chk("clear_on_hit", vec_a, 48'h0);

    // Randomized blocked runs on dut_a.
    for (int ep = 0; ep < 6; ep++) begin
      len     = $urandom_range(1000, 1100);
      drop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
      for (int k = 1; k <= len; k++) begin
        step_a(k != drop_at, 1'b1, rnd_info(), rnd_pct(50), ($urandom_range(0, 999) == 0));
      end
      repeat ($urandom_range(0, 4)) step_a(1'b1, rnd_pct(50), rnd_info(), 1'b0, 1'b0);
      step_a(1'b1, rnd_pct(50), rnd_info(), 1'b1, 1'b0);
      repeat ($urandom_range(1, 3)) step_a(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    end

    // Saturation on dut_b: 4096 deadlock events.
    for (int ev = 1; ev <= 4096; ev++) begin
      step_b(1'b1, 1'b1, rnd_info(), 1'b0, 1'b0);
      step_b(1'b1, 1'b1, rnd_info(), 1'b0, 1'b0);
      if (ev == 3)
        chk("early_count", {23'd0, v_b, data_b[31:20], ec_b}, {23'd0, 1'b1, 12'd3, 12'd3});
      if (ev >= 4095)
        chk("saturated_report", {23'd0, v_b, data_b[31:20], ec_b}, {23'd0, 1'b1, 12'hFFF, 12'hFFF});
      repeat ($urandom_range(0, 1)) step_b(1'b1, 1'b1, rnd_info(), 1'b0, 1'b0);
      step_b(1'b1, 1'b1, rnd_info(), 1'b1, 1'b0);
      step_b(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    end
    chk("count_holds_4095", {36'd0, ec_b}, {36'd0, 12'hFFF});

    // Reset in the middle of a report withdraws it without a handshake.
    step_b(1'b1, 1'b1, rnd_info(), 1'b0, 1'b0);
    step_b(1'b1, 1'b1, rnd_info(), 1'b0, 1'b0);
    chk("report_before_reset", {47'd0, v_b}, 48'd1);
    rst_b = 1'b1;
    step_b(1'b1, 1'b1, rnd_info(), 1'b0, 1'b0);
    chk("reset_in_report", vec_b, 48'h0);
    rst_b = 1'b0;

    // Fully random traffic on dut_b.
    for (int i = 0; i < 3000; i++) begin
      rst_b = ($urandom_range(0, 199) == 0);
      step_b(rnd_pct(90), rnd_pct(75), rnd_info(), rnd_pct(50), ($urandom_range(0, 99) == 0));
    end
    rst_b = 1'b0;
    step_b(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    finish_sim();
  end

endmodule
